dmem_mmio_responder: RTL and testbench
======================================

# dmem_mmio_responder

Data-side memory responder for the five-stage core's Memory-stage port. It answers the core's address, write-data and write-strobe outputs with a same-cycle `ReadData`. Word addresses decode into a data RAM, an LED register, a free-running cycle counter and an 8-entry byte FIFO that drains to an external character sink over a valid/ready handshake. It sits beside the core in the top level, wired to `OpResult`, `WriteData`, `MemWrite` and `ReadData`.

## Interface
- `RAM_WORDS`, 128: data RAM depth in 32-bit words; power of two.
- `TX_DEPTH`, 8: TX FIFO depth in bytes; power of two, 2..16.
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `MemWrite`  in  1  write strobe from the core's M stage.
- `Addr`  in  32  byte address (core `OpResult`); `Addr[1:0]` ignored.
- `WriteData`  in  32  store data from the core.
- `ReadData`  out  32  combinational read data for `Addr`.
- `LED`  out  16  LED register contents.
- `TxData`  out  8  FIFO head byte.
- `TxValid`  out  1  FIFO non-empty.
- `TxReady`  in  1  sink accepts `TxData` this cycle.

## Operation
- Address map (word aligned):
  - `0x800`..`0x800+4*RAM_WORDS-1`: RAM, read/write.
  - `0xC00`: LED. Read returns `{16'b0, LED}`. Write loads `WriteData[15:0]`.
  - `0xC04`: CYCLE. Read returns the counter. Any write clears it.
  - `0xC08`: TXDATA. Write pushes `WriteData[7:0]`. Read returns 0.
  - `0xC0C`: TXSTAT. Read returns the status word: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count. Any write clears overflow.
- Unmapped reads return 0. Unmapped writes are ignored. No bus error.
- RAM index is `Addr[2+log2(RAM_WORDS)-1:2]` within the RAM window. Contents are not cleared by `Reset`.
- Cycle counter increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0. In a cycle with a write to CYCLE, the next value is 0, not 1.
- TX FIFO: circular buffer with read pointer, write pointer and count.
  - Push: a write to TXDATA while not full.
  - Pop: `TxValid && TxReady`.
  - Push while full with no pop in the same cycle: byte dropped, overflow bit set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push into an empty FIFO does not fall through. `TxValid` rises the next cycle.
  - Pointers wrap modulo `TX_DEPTH`.
- `TxData` is the head entry whenever `TxValid` is high. It is held stable while `TxValid && !TxReady`.

## Timing
- Read latency 0: `ReadData` is combinational from `Addr` and current state.
- A write at edge N is visible to a read of the same address in cycle N+1. No write-to-read bypass within a cycle.
- Reset values: `LED`=0, counter=0, FIFO empty, overflow=0, `TxValid`=0, `TxData`=0. `ReadData` follows the decode.
- `Reset` asserted mid-drain discards FIFO contents. Any write in the reset cycle is ignored, including RAM writes.
- After reset deasserts, CYCLE reads 0 in the first cycle and 1 in the next.

## Structure
- Shared package `mmio_pkg`:
  - address constants `RAM_BASE`, `LED_ADDR`, `CYCLE_ADDR`, `TXDATA_ADDR`, `TXSTAT_ADDR`;
  - status bit positions.
- One sub-module, `tx_fifo`: parameter `DEPTH`; ports `push`, `din`, `pop`, `dout`, `full`, `empty`, `count`, `overflow`, `clr_ovf`.
- Address decode, RAM array, LED register, counter and read mux live in the top.

## Test plan
- Reset, then write `0xDEADBEEF` to `0x804` and read `0x804` next cycle: `ReadData=0xDEADBEEF`. Read `0x800`: whatever was stored (not a reset value). Read `0x400`: 0.
- Write `0x0001_A5C3` to `0xC00`: `LED=0xA5C3`, and `0xC00` reads `0x0000_A5C3`. Assert `Reset`: `LED=0` the next cycle.
- Deassert reset and read CYCLE for 10 cycles: values 0..9. Write CYCLE at value 9: the next read is 0. Force the counter to `0xFFFF_FFFF`: the next cycle reads 0.
- `TxReady=0`, push bytes `0x41`..`0x48`: TXSTAT shows full=1 and count=8. Push a 9th byte: overflow=1 and count stays 8. Raise `TxReady`: bytes `0x41`..`0x48` drain one per cycle in order, then `TxValid=0` and empty=1. Write TXSTAT: overflow=0.
- With the FIFO full, push and pop in the same cycle: count stays 8, overflow=0, and the new byte drains last.
- Push `0x55` into an empty FIFO with `TxReady=1`: `TxValid` rises one cycle after the write and drops the cycle after the pop. Assert `Reset` while 3 bytes are queued: `TxValid=0` and count=0 the next cycle.

Source files
------------

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared address map, decode select codes and TX status-word layout for the
// data-side MMIO responder.
package mmio_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0800;
  localparam logic [31:0] LED_ADDR    = 32'h0000_0C00;
  localparam logic [31:0] CYCLE_ADDR  = 32'h0000_0C04;
  localparam logic [31:0] TXDATA_ADDR = 32'h0000_0C08;
  localparam logic [31:0] TXSTAT_ADDR = 32'h0000_0C0C;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_MSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_RAM    = 3'd1,
    SEL_LED    = 3'd2,
    SEL_CYCLE  = 3'd3,
    SEL_TXDATA = 3'd4,
    SEL_TXSTAT = 3'd5
  } sel_e;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [4:0] cnt);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_COUNT_MSB:STAT_COUNT_LSB] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core-side data bus plus the character-sink handshake seen by the responder.
interface dmem_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output MemWrite, Addr, WriteData, TxReady,
    input  ReadData, TxData, TxValid
  );

  modport slave (
    input  MemWrite, Addr, WriteData, TxReady,
    output ReadData, TxData, TxValid
  );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte FIFO feeding the character sink; no fall-through, sticky overflow on
// a push that finds the buffer full with no simultaneous pop.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic          ovf_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty    = (count_r == {(PW+1){1'b0}});
  assign full     = (count_r == (PW+1)'(DEPTH));
  assign count    = count_r;
  assign overflow = ovf_r;
  assign dout     = empty ? 8'h00 : mem_r[rd_ptr_r];

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointers, occupancy and overflow flag; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push && full && !do_pop_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-stage responder: decodes word addresses into data RAM, LED register,
// free-running cycle counter and TX FIFO, returning same-cycle read data.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS = 128,
  parameter int TX_DEPTH  = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  dmem_mmio_responder_if.slave  bus,
  output logic [15:0]           LED
);
  localparam int          AW      = $clog2(RAM_WORDS);
  localparam int          CW      = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_END = RAM_BASE + 32'(4 * RAM_WORDS);

  logic [31:0]   word_addr_s;
  logic [AW-1:0] ram_idx_s;
  sel_e          sel_s;
  logic          wr_en_s;
  logic [31:0]   rdata_s;

  logic [31:0]   ram_r [RAM_WORDS];
  logic [15:0]   led_r;
  logic [31:0]   cycle_r;

  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_clr_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_ovf_s;

  assign word_addr_s = bus.Addr & 32'hFFFF_FFFC;
  assign ram_idx_s   = word_addr_s[AW+1:2];
  // Writes presented during the reset cycle are dropped everywhere.
  assign wr_en_s     = bus.MemWrite && !Reset;

  // Address decode into one target select.
  always_comb begin
    sel_s = SEL_NONE;
    if ((word_addr_s >= RAM_BASE) && (word_addr_s < RAM_END)) begin
      sel_s = SEL_RAM;
    end else begin
      case (word_addr_s)
        LED_ADDR:    sel_s = SEL_LED;
        CYCLE_ADDR:  sel_s = SEL_CYCLE;
        TXDATA_ADDR: sel_s = SEL_TXDATA;
        TXSTAT_ADDR: sel_s = SEL_TXSTAT;
        default:     sel_s = SEL_NONE;
      endcase
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s && (sel_s == SEL_RAM)) begin
      ram_r[ram_idx_s] <= bus.WriteData;
    end
  end

  // LED register and cycle counter; a CYCLE write restarts the count at 0.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      led_r   <= 16'h0000;
      cycle_r <= 32'h0000_0000;
    end else begin
      if (wr_en_s && (sel_s == SEL_LED)) begin
        led_r <= bus.WriteData[15:0];
      end
      if (wr_en_s && (sel_s == SEL_CYCLE)) begin
        cycle_r <= 32'h0000_0000;
      end else begin
        cycle_r <= cycle_r + 32'h0000_0001;
      end
    end
  end

  assign fifo_push_s = wr_en_s && (sel_s == SEL_TXDATA);
  assign fifo_pop_s  = !fifo_empty_s && bus.TxReady;
  assign fifo_clr_s  = wr_en_s && (sel_s == SEL_TXSTAT);

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (CLK),
    .rst      (Reset),
    .push     (fifo_push_s),
    .din      (bus.WriteData[7:0]),
    .pop      (fifo_pop_s),
    .dout     (fifo_dout_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s),
    .overflow (fifo_ovf_s),
    .clr_ovf  (fifo_clr_s)
  );

  // Zero-latency read mux; TXDATA and unmapped addresses read as 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sel_s)
      SEL_RAM:    rdata_s = ram_r[ram_idx_s];
      SEL_LED:    rdata_s = {16'h0000, led_r};
      SEL_CYCLE:  rdata_s = cycle_r;
      SEL_TXSTAT: rdata_s = pack_status(fifo_full_s, fifo_empty_s, fifo_ovf_s,
                                        5'(fifo_count_s));
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.ReadData = rdata_s;
  assign bus.TxData   = fifo_dout_s;
  assign bus.TxValid  = !fifo_empty_s;
  assign LED          = led_r;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder: RAM, LED, cycle
// counter and TX FIFO behaviour with hand-computed expectations.
module tb_dmem_mmio_responder;
  import mmio_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  int          checks;
  int          errors;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .RAM_WORDS (128),
    .TX_DEPTH  (8)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus),
    .LED   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.Addr     = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.MemWrite = 1'b0; bus.Addr = 32'h0; bus.WriteData = 32'h0; bus.TxReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.Addr = CYCLE_ADDR;
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_cycle0: got %h expected %h", bus.ReadData, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid: got %b expected 0", bus.TxValid); end
    checks++; if (bus.TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", bus.TxData); end
    @(negedge clk);
    #1;
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL reset_cycle1: got %h expected %h", bus.ReadData, 32'h1); end
    bus.Addr = TXSTAT_ADDR;
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0002) begin errors++; $display("FAIL reset_txstat: got %h expected %h", bus.ReadData, 32'h2); end
  endtask

  task automatic test_ram;
    logic [31:0] d;
    wr(32'h800, 32'h1234_5678);
    wr(32'h804, 32'hDEAD_BEEF);
    rd(32'h804, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_804: got %h expected %h", d, 32'hDEAD_BEEF); end
    rd(32'h800, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_800: got %h expected %h", d, 32'h1234_5678); end
    rd(32'h400, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_400: got %h expected %h", d, 32'h0); end
    rd(32'h806, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_lowbits: got %h expected %h", d, 32'hDEAD_BEEF); end
    wr(32'h9FC, 32'hCAFE_F00D);
    rd(32'h9FC, d);
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_last: got %h expected %h", d, 32'hCAFE_F00D); end
    wr(32'hA00, 32'hFFFF_FFFF);
    rd(32'hA00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_past_end: got %h expected %h", d, 32'h0); end
    // Same-cycle read during a write must still show the old word.
    wr(32'h804, 32'h0BAD_F00D);
    #1;
    checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_no_bypass: got %h expected %h", bus.ReadData, 32'hDEAD_BEEF); end
    rd(32'h804, d);
    checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_rewrite: got %h expected %h", d, 32'h0BAD_F00D); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) wr(32'h900 + 32'(4 * i), 32'hA000_0000 + 32'(i * 3));
    for (int i = 0; i < 4; i++) begin
      rd(32'h900 + 32'(4 * i), d);
      checks++; if (d !== 32'hA000_0000 + 32'(i * 3)) begin errors++; $display("FAIL b2b_%0d: got %h expected %h", i, d, 32'hA000_0000 + 32'(i * 3)); end
    end
  endtask

  task automatic test_led;
    logic [31:0] d;
    wr(LED_ADDR, 32'h0001_A5C3);
    rd(LED_ADDR, d);
    checks++; if (d !== 32'h0000_A5C3) begin errors++; $display("FAIL led_read: got %h expected %h", d, 32'h0000_A5C3); end
    checks++; if (led !== 16'hA5C3) begin errors++; $display("FAIL led_port: got %h expected %h", led, 16'hA5C3); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL led_reset: got %h expected %h", led, 16'h0); end
    rst = 1'b0;
  endtask

  task automatic test_reset_write;
    logic [31:0] d;
    wr(32'h808, 32'h1111_1111);
    @(negedge clk);
    rst = 1'b1; bus.MemWrite = 1'b1; bus.Addr = 32'h808; bus.WriteData = 32'h2222_2222;
    @(negedge clk);
    rst = 1'b0; bus.MemWrite = 1'b0;
    rd(32'h808, d);
    checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL reset_write_ignored: got %h expected %h", d, 32'h1111_1111); end
  endtask

  task automatic test_cycle;
    @(negedge clk);
    rst = 1'b1; bus.MemWrite = 1'b0; bus.Addr = CYCLE_ADDR;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus.ReadData !== 32'(i)) begin errors++; $display("FAIL cycle_seq_%0d: got %h expected %h", i, bus.ReadData, 32'(i)); end
    end
    bus.MemWrite = 1'b1; bus.WriteData = 32'h0000_1234;
    @(negedge clk);
    bus.MemWrite = 1'b0;
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL cycle_clear: got %h expected %h", bus.ReadData, 32'h0); end
    @(negedge clk);
    #1;
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL cycle_after_clear: got %h expected %h", bus.ReadData, 32'h1); end
    @(negedge clk);
    force dut.cycle_r = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_forced: got %h expected %h", bus.ReadData, 32'hFFFF_FFFF); end
    #1;
    release dut.cycle_r;
    @(negedge clk);
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h expected %h", bus.ReadData, 32'h0); end
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] d;
    logic [7:0]  exp;
    bus.TxReady = 1'b0;
    for (int i = 0; i < 8; i++) wr(TXDATA_ADDR, 32'(8'h41 + 8'(i)));
    rd(TXSTAT_ADDR, d);
    checks++; if (d !== 32'h0000_0081) begin errors++; $display("FAIL fifo_full_stat: got %h expected %h", d, 32'h81); end
    rd(TXDATA_ADDR, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected %h", d, 32'h0); end
    wr(TXDATA_ADDR, 32'h0000_0049);
    rd(TXSTAT_ADDR, d);
    checks++; if (d !== 32'h0000_0085) begin errors++; $display("FAIL fifo_ovf_stat: got %h expected %h", d, 32'h85); end
    @(negedge clk);
    bus.TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp = 8'h41 + 8'(i);
      checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== exp) begin errors++; $display("FAIL drain_%0d: got valid %b data %h expected valid 1 data %h", i, bus.TxValid, bus.TxData, exp); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL drain_done_valid: got %b expected 0", bus.TxValid); end
    bus.TxReady = 1'b0;
    rd(TXSTAT_ADDR, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL drain_done_stat: got %h expected %h", d, 32'h6); end
    wr(TXSTAT_ADDR, 32'h0);
    rd(TXSTAT_ADDR, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h2); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] exp;
    bus.TxReady = 1'b0;
    for (int i = 0; i < 8; i++) wr(TXDATA_ADDR, 32'(8'h61 + 8'(i)));
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.Addr = TXDATA_ADDR; bus.WriteData = 32'h0000_0069; bus.TxReady = 1'b1;
    @(negedge clk);
    bus.MemWrite = 1'b0; bus.TxReady = 1'b0; bus.Addr = TXSTAT_ADDR;
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0081) begin errors++; $display("FAIL pushpop_stat: got %h expected %h", bus.ReadData, 32'h81); end
    @(negedge clk);
    bus.TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp = 8'h62 + 8'(i);
      checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== exp) begin errors++; $display("FAIL pushpop_drain_%0d: got valid %b data %h expected valid 1 data %h", i, bus.TxValid, bus.TxData, exp); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b expected 0", bus.TxValid); end
    bus.TxReady = 1'b0;
  endtask

  task automatic test_fall_through;
    logic [31:0] d;
    @(negedge clk);
    bus.TxReady = 1'b1; bus.MemWrite = 1'b1; bus.Addr = TXDATA_ADDR; bus.WriteData = 32'h0000_0055;
    #1;
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL no_fallthrough: got %b expected 0", bus.TxValid); end
    @(negedge clk);
    bus.MemWrite = 1'b0;
    #1;
    checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== 8'h55) begin errors++; $display("FAIL single_valid: got valid %b data %h expected valid 1 data 55", bus.TxValid, bus.TxData); end
    @(negedge clk);
    #1;
    checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", bus.TxValid); end
    bus.TxReady = 1'b0;
    for (int i = 0; i < 3; i++) wr(TXDATA_ADDR, 32'(8'h70 + 8'(i)));
    rd(TXSTAT_ADDR, d);
    checks++; if (d !== 32'h0000_0030) begin errors++; $display("FAIL three_queued: got %h expected %h", d, 32'h30); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.TxValid !== 1'b0 || bus.TxData !== 8'h00) begin errors++; $display("FAIL reset_drain: got valid %b data %h expected valid 0 data 00", bus.TxValid, bus.TxData); end
    checks++; if (bus.ReadData !== 32'h0000_0002) begin errors++; $display("FAIL reset_drain_stat: got %h expected %h", bus.ReadData, 32'h2); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram();
    test_back_to_back();
    test_led();
    test_reset_write();
    test_cycle();
    test_fifo_overflow();
    test_push_pop_full();
    test_fall_through();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
